data_mem_responder: RTL



---
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// CPU data-port bus plus the console drain port and timer interrupt of the
// data memory responder. The master side is the CPU/SoC, the slave side the responder.
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_byte_slct;
    logic [DATA_WIDTH-1:0] data_to_write_mem;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] data_from_mem;
    logic [7:0]            con_data;
    logic                  con_valid;
    logic                  con_ready;
    logic                  timer_irq;

    modport master (
        output mem_addr, mem_byte_slct, data_to_write_mem, mem_we, mem_re, con_ready,
        input  data_from_mem, con_data, con_valid, timer_irq
    );

    modport slave (
        input  mem_addr, mem_byte_slct, data_to_write_mem, mem_we, mem_re, con_ready,
        output data_from_mem, con_data, con_valid, timer_irq
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM with byte-lane writes and zero-latency
// reads, plus an MMIO window holding a cycle counter, a compare timer with a
// sticky pending flag and a console transmit FIFO.
module data_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    RAM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int                    CON_DEPTH  = 8
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_responder_if.slave  bus
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CON_AW = $clog2(CON_DEPTH);
    localparam logic [CON_AW-1:0] PTR_ONE  = CON_AW'(1);
    localparam logic [CON_AW:0]   CNT_ONE  = (CON_AW + 1)'(1);
    localparam logic [CON_AW:0]   CNT_FULL = (CON_AW + 1)'(CON_DEPTH);

    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
    logic [7:0]            con_mem [CON_DEPTH];

    logic [31:0]       cycle;
    logic [31:0]       timer_cmp;
    logic              pending;
    logic              overflow;
    logic [CON_AW-1:0] rd_ptr;
    logic [CON_AW-1:0] wr_ptr;
    logic [CON_AW:0]   con_count;

    logic [RAM_AW-1:0]     ram_idx;
    logic [13:0]           reg_sel;
    logic                  is_mmio;
    logic                  wr_ram;
    logic                  wr_mmio;
    logic                  con_full;
    logic                  con_empty;
    logic                  con_pop;
    logic                  con_push_req;
    logic                  con_push;
    logic                  timer_hit;
    logic                  irq_clr_wr;
    logic                  cmp_wr;
    logic [31:0]           count_ext;
    logic [3:0]            count_disp;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_addr_bits;

    // Byte offset bits are meaningless here: lane selects come from the CPU.
    assign unused_addr_bits = ^bus.mem_addr[1:0];

    assign ram_idx = bus.mem_addr[RAM_AW+1:2];
    assign reg_sel = bus.mem_addr[15:2];
    assign is_mmio = (bus.mem_addr >= MMIO_BASE);
    assign wr_ram  = bus.mem_we && !is_mmio;
    assign wr_mmio = bus.mem_we && is_mmio;

    assign con_full     = (con_count == CNT_FULL);
    assign con_empty    = (con_count == '0);
    assign con_pop      = !con_empty && bus.con_ready;
    assign con_push_req = wr_mmio && (reg_sel == 14'd3) && bus.mem_byte_slct[0];
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign con_push     = con_push_req && (!con_full || con_pop);

    assign timer_hit  = (timer_cmp != 32'd0) && (cycle == timer_cmp);
    assign irq_clr_wr = wr_mmio && (reg_sel == 14'd4);
    assign cmp_wr     = wr_mmio && (reg_sel == 14'd1);

    assign count_ext  = 32'(con_count);
    assign count_disp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    // Zero-latency read mux; RAM returns the full word and the CPU extracts lanes.
    always_comb begin
        rdata = '0;
        if (bus.mem_re) begin
            if (is_mmio) begin
                case (reg_sel)
                    14'd0:   rdata = cycle;
                    14'd1:   rdata = timer_cmp;
                    14'd2:   rdata = {24'd0, count_disp, overflow, con_empty, con_full, pending};
                    default: rdata = '0;
                endcase
            end else begin
                rdata = ram[ram_idx];
            end
        end
    end

    assign bus.data_from_mem = rst ? rdata : '0;
    assign bus.con_data      = con_mem[rd_ptr];
    assign bus.con_valid     = !con_empty;
    assign bus.timer_irq     = pending;

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_ram && bus.mem_byte_slct[i]) begin
                ram[ram_idx][8*i +: 8] <= bus.data_to_write_mem[8*i +: 8];
            end
        end
    end

    // Peripheral state: counter, timer, sticky flags and the console FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle     <= '0;
            timer_cmp <= '0;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            con_count <= '0;
            for (int i = 0; i < CON_DEPTH; i++) begin
                con_mem[i] <= '0;
            end
        end else begin
            cycle <= cycle + 32'd1;

            for (int i = 0; i < 4; i++) begin
                if (cmp_wr && bus.mem_byte_slct[i]) begin
                    timer_cmp[8*i +: 8] <= bus.data_to_write_mem[8*i +: 8];
                end
            end

            if (timer_hit) begin
                pending <= 1'b1;
            end else if (irq_clr_wr && bus.data_to_write_mem[0]) begin
                pending <= 1'b0;
            end

            if (con_push_req && !con_push) begin
                overflow <= 1'b1;
            end else if (irq_clr_wr && bus.data_to_write_mem[1]) begin
                overflow <= 1'b0;
            end

            if (con_push) begin
                con_mem[wr_ptr] <= bus.data_to_write_mem[7:0];
                wr_ptr          <= wr_ptr + PTR_ONE;
            end
            if (con_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (con_push && !con_pop) begin
                con_count <= con_count + CNT_ONE;
            end else if (!con_push && con_pop) begin
                con_count <= con_count - CNT_ONE;
            end
        end
    end
endmodule
